// File: rtl/player_pkg.sv
// Shared constants for the player-state block: field widths, status-word
// bit positions and default parameter values.
package player_pkg;

   localparam int POS_W   = 3;
   localparam int LIVES_W = 2;

   localparam int POS_LSB       = 0;
   localparam int SHOT_BIT      = 3;
   localparam int HIT_BIT       = 4;
   localparam int GAME_OVER_BIT = 5;
   localparam int LIVES_LSB     = 6;

   localparam int DEF_POS_RESET     = 3;
   localparam int DEF_LIVES_INIT    = 3;
   localparam int DEF_FIRE_COOLDOWN = 4;
   localparam int DEF_HIT_GRACE     = 8;

   localparam logic [POS_W-1:0] POS_MAX = '1;

endpackage

// File: rtl/player_controller_edge_detect.sv
// Rising-edge detector; the previous-value register resets high so a level
// held through reset is not reported as a press.
module edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise
);

   logic prev_q;
   logic prev_d;

   always_comb begin
      prev_d = din;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         prev_q <= 1'b1;
      end else begin
         prev_q <= prev_d;
      end
   end

   assign rise = din & ~prev_q;

endmodule

// File: rtl/player_controller.sv
// Player position, fire cooldown, hit grace and lives tracking; publishes a
// registered 8-bit status word every cycle.
module player_controller
   import player_pkg::*;
#(
   parameter int POS_RESET     = DEF_POS_RESET,
   parameter int LIVES_INIT    = DEF_LIVES_INIT,
   parameter int FIRE_COOLDOWN = DEF_FIRE_COOLDOWN,
   parameter int HIT_GRACE     = DEF_HIT_GRACE
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       button_up,
   input  logic       button_down,
   input  logic       is_firing,
   input  logic       projectile,
   output logic [7:0] data_out
);

   localparam int CD_W = $clog2(FIRE_COOLDOWN + 1);
   localparam int GR_W = $clog2(HIT_GRACE + 1);

   logic [2:0] btn_raw;
   logic [2:0] btn_press;

   assign btn_raw = {is_firing, button_down, button_up};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_edge
         edge_detect u_edge (
            .clk  (clk),
            .rst  (rst),
            .din  (btn_raw[gi]),
            .rise (btn_press[gi])
         );
      end
   endgenerate

   logic [POS_W-1:0]   pos_q, pos_d;
   logic [LIVES_W-1:0] lives_q, lives_d;
   logic [CD_W-1:0]    cool_q, cool_d;
   logic [GR_W-1:0]    grace_q, grace_d;
   logic               over_q, over_d;
   logic               shot_q, shot_d;
   logic               hit_q, hit_d;
   logic               game_ends;
   logic               move_up, move_dn;

   assign move_up = btn_press[0] & ~btn_press[1];
   assign move_dn = btn_press[1] & ~btn_press[0];

   always_comb begin
      pos_d     = pos_q;
      lives_d   = lives_q;
      over_d    = over_q;
      shot_d    = 1'b0;
      hit_d     = 1'b0;
      game_ends = 1'b0;
      cool_d    = (cool_q != '0) ? cool_q - 1'b1 : cool_q;
      grace_d   = (grace_q != '0) ? grace_q - 1'b1 : grace_q;

      if (!over_q) begin
         if (projectile && grace_q == '0) begin
            hit_d   = 1'b1;
            lives_d = lives_q - 1'b1;
            grace_d = GR_W'(HIT_GRACE);
            if (lives_q == LIVES_W'(1)) begin
               over_d    = 1'b1;
               game_ends = 1'b1;
            end
         end
         // The fatal hit takes precedence: the same-cycle move and shot are dropped.
         if (!game_ends) begin
            if (move_up && pos_q != POS_MAX) begin
               pos_d = pos_q + 1'b1;
            end else if (move_dn && pos_q != '0) begin
               pos_d = pos_q - 1'b1;
            end
            if (btn_press[2] && cool_q == '0) begin
               shot_d = 1'b1;
               cool_d = CD_W'(FIRE_COOLDOWN);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pos_q   <= POS_W'(POS_RESET);
         lives_q <= LIVES_W'(LIVES_INIT);
         cool_q  <= '0;
         grace_q <= '0;
         over_q  <= 1'b0;
         shot_q  <= 1'b0;
         hit_q   <= 1'b0;
      end else begin
         pos_q   <= pos_d;
         lives_q <= lives_d;
         cool_q  <= cool_d;
         grace_q <= grace_d;
         over_q  <= over_d;
         shot_q  <= shot_d;
         hit_q   <= hit_d;
      end
   end

   always_comb begin
      data_out = '0;
      data_out[POS_LSB +: POS_W]     = pos_q;
      data_out[SHOT_BIT]             = shot_q;
      data_out[HIT_BIT]              = hit_q;
      data_out[GAME_OVER_BIT]        = over_q;
      data_out[LIVES_LSB +: LIVES_W] = lives_q;
   end

endmodule

// File: tb/tb_player_controller.sv
// Directed plus randomized checks of player_controller against a cycle-count
// based reference model of the player rules.
module tb_player_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic       button_up, button_down, is_firing, projectile;
   logic [7:0] data_out;

   player_controller dut (
      .clk         (clk),
      .rst         (rst),
      .button_up   (button_up),
      .button_down (button_down),
      .is_firing   (is_firing),
      .projectile  (projectile),
      .data_out    (data_out)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_value(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // Reference model: cooldown and grace are tracked as "cycles since last
   // shot/hit" rather than as down-counters.
   int m_pos, m_lives, m_over, m_shot, m_hit;
   int m_last_shot, m_last_hit;
   int m_prev_u, m_prev_d, m_prev_f;
   int cyc = 0;
   int shot_cnt = 0;
   int hit_cnt = 0;
   int hit_at[$];

   task automatic model_step(input logic u, input logic d, input logic f,
                             input logic p, input logic r);
      int pu, pd, pf, ends;
      if (!r) begin
         m_pos = 3; m_lives = 3; m_over = 0; m_shot = 0; m_hit = 0;
         m_last_shot = -1000; m_last_hit = -1000;
         m_prev_u = 1; m_prev_d = 1; m_prev_f = 1;
      end else begin
         pu = (u && !m_prev_u) ? 1 : 0;
         pd = (d && !m_prev_d) ? 1 : 0;
         pf = (f && !m_prev_f) ? 1 : 0;
         m_prev_u = u; m_prev_d = d; m_prev_f = f;
         m_shot = 0; m_hit = 0; ends = 0;
         if (m_over == 0) begin
            if (p && (cyc - m_last_hit) >= 9) begin
               m_hit = 1;
               m_lives = m_lives - 1;
               m_last_hit = cyc;
               if (m_lives == 0) begin
                  m_over = 1;
                  ends = 1;
               end
            end
            if (ends == 0) begin
               if (pu && !pd && m_pos < 7) m_pos = m_pos + 1;
               if (pd && !pu && m_pos > 0) m_pos = m_pos - 1;
               if (pf && (cyc - m_last_shot) >= 5) begin
                  m_shot = 1;
                  m_last_shot = cyc;
               end
            end
         end
      end
   endtask

   function automatic logic [7:0] model_word();
      logic [7:0] w;
      w[2:0] = 3'(m_pos);
      w[3]   = (m_shot != 0);
      w[4]   = (m_hit != 0);
      w[5]   = (m_over != 0);
      w[7:6] = 2'(m_lives);
      return w;
   endfunction

   task automatic step(input logic u, input logic d, input logic f,
                       input logic p, input logic r);
      button_up = u; button_down = d; is_firing = f; projectile = p; rst = r;
      @(posedge clk);
      #1;
      model_step(u, d, f, p, r);
      check_value("dout", data_out, model_word());
      if (data_out[3]) shot_cnt++;
      if (data_out[4]) begin
         hit_cnt++;
         hit_at.push_back(cyc);
      end
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      rst = 1'b0; button_up = 1'b0; button_down = 1'b0; is_firing = 1'b0; projectile = 1'b0;

      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      check_value("reset_word", data_out, 8'b11000011);
      idle(1);

      for (int i = 0; i < 5; i++) begin
         step(1, 0, 0, 0, 1);
         step(0, 0, 0, 0, 1);
      end
      check_value("pos_sat_up", {5'd0, data_out[2:0]}, 8'd7);
      for (int i = 0; i < 8; i++) begin
         step(0, 1, 0, 0, 1);
         step(0, 0, 0, 0, 1);
      end
      check_value("pos_sat_down", {5'd0, data_out[2:0]}, 8'd0);
      for (int i = 0; i < 2; i++) begin
         step(1, 0, 0, 0, 1);
         step(0, 0, 0, 0, 1);
      end
      step(1, 1, 0, 0, 1);
      check_value("pos_both", {5'd0, data_out[2:0]}, 8'd2);
      idle(1);

      step(0, 0, 1, 0, 1);
      check_value("shot_first", {7'd0, data_out[3]}, 8'd1);
      step(0, 0, 0, 0, 1);
      check_value("shot_one_cycle", {7'd0, data_out[3]}, 8'd0);
      step(0, 0, 1, 0, 1);
      check_value("shot_dropped", {7'd0, data_out[3]}, 8'd0);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      step(0, 0, 1, 0, 1);
      check_value("shot_after_cd", {7'd0, data_out[3]}, 8'd1);
      idle(6);
      shot_cnt = 0;
      for (int i = 0; i < 20; i++) step(0, 0, 1, 0, 1);
      check_value("fire_held", 8'(shot_cnt), 8'd1);
      idle(2);

      hit_cnt = 0;
      hit_at.delete();
      for (int i = 0; i < 30; i++) step(0, 0, 0, 1, 1);
      check_value("hit_count", 8'(hit_cnt), 8'd3);
      if (hit_at.size() >= 3) begin
         check_value("hit_gap1", 8'(hit_at[1] - hit_at[0]), 8'd9);
         check_value("hit_gap2", 8'(hit_at[2] - hit_at[1]), 8'd9);
      end
      check_value("game_over", {5'd0, data_out[7:5]}, 8'b001);
      step(1, 0, 0, 0, 1); step(0, 0, 0, 0, 1);
      step(0, 1, 0, 0, 1); step(0, 0, 0, 0, 1);
      step(0, 0, 1, 0, 1);
      check_value("freeze", data_out, 8'h22);

      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 1);
      idle(9);
      step(0, 0, 0, 1, 1);
      check_value("lives_one", {6'd0, data_out[7:6]}, 8'd1);
      step(0, 0, 1, 0, 1);
      step(0, 0, 0, 0, 0);
      check_value("mid_reset", data_out, 8'b11000011);
      step(0, 0, 0, 0, 1);
      step(0, 0, 1, 0, 1);
      check_value("fire_after_reset", {7'd0, data_out[3]}, 8'd1);

      for (int i = 0; i < 3000; i++) begin
         step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0),
              1'($urandom_range(0, 199) != 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
